mul_2bit_gather: RTL and testbench

//  Sequencer/accumulator around the registered 2-bit digit multiplier. Accepts one pair of

---
 rtl/mul_2bit_gather_if.sv | 27 ++
 rtl/mul_2bit_gather.sv | 140 ++++++++++++++
 tb/tb_mul_2bit_gather.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_2bit_gather_if.sv
// Handshake and digit-multiplier bus of mul_2bit_gather.
// The slave side is the sequencer and the master side is its environment.
interface mul_2bit_gather_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [1:0]         mul_a;
  logic [1:0]         mul_b;
  logic               mul_en;
  logic [3:0]         mul_p;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;

  modport slave (
    input  in_valid, in_a, in_b, mul_p, out_ready,
    output in_ready, mul_a, mul_b, mul_en, out_valid, out_p
  );

  modport master (
    output in_valid, in_a, in_b, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, mul_en, out_valid, out_p
  );
endinterface

// File: rtl/mul_2bit_gather.sv
// Scatters two WIDTH-bit operands into 2-bit digit pairs for an external registered multiplier,
// then gathers the 4-bit partial products into a 2*WIDTH-bit shift-add product.
module mul_2bit_gather #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  mul_2bit_gather_if.slave  bus_io
);
  localparam int unsigned N    = WIDTH / 2;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ShW  = $clog2(PW);
  localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CntW-1:0]    i_q, i_d;
  logic [CntW-1:0]    j_q, j_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [MUL_LAT-1:0] dl_vld_q;
  logic [ShW-1:0]     dl_sh_q [MUL_LAT];

  logic               issue;
  logic [ShW-1:0]     issue_sh;
  logic [PW-1:0]      addend;
  logic               in_ready;
  logic               out_valid;
  logic [PW-1:0]      out_p;
  logic [1:0]         mul_a;
  logic [1:0]         mul_b;
  logic               mul_en;

  assign issue_sh = (ShW'(i_q) + ShW'(j_q)) << 1;
  // mul_p is only meaningful in the cycle its delay-line entry emerges.
  assign addend   = PW'(bus_io.mul_p) << dl_sh_q[MUL_LAT-1];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    i_d       = i_q;
    j_d       = j_q;
    acc_d     = acc_q;
    issue     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_p     = '0;
    mul_a     = '0;
    mul_b     = '0;
    mul_en    = 1'b0;

    if (dl_vld_q[MUL_LAT-1]) begin
      acc_d = acc_q + addend;
    end

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (bus_io.in_valid) begin
          a_d     = bus_io.in_a;
          b_d     = bus_io.in_b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        issue  = 1'b1;
        mul_en = 1'b1;
        mul_a  = a_q[{i_q, 1'b0} +: 2];
        mul_b  = b_q[{j_q, 1'b0} +: 2];
        if (j_q == LastIdx) begin
          j_d = '0;
          if (i_q == LastIdx) begin
            i_d     = '0;
            state_d = StDrain;
          end else begin
            i_d = i_q + CntW'(1);
          end
        end else begin
          j_d = j_q + CntW'(1);
        end
      end
      StDrain: begin
        if (dl_vld_q == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        out_p     = acc_q;
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      dl_vld_q <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        dl_sh_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      dl_vld_q[0] <= issue;
      dl_sh_q[0]  <= issue_sh;
      for (int k = 1; k < MUL_LAT; k++) begin
        dl_vld_q[k] <= dl_vld_q[k-1];
        dl_sh_q[k]  <= dl_sh_q[k-1];
      end
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = out_valid;
  assign bus_io.out_p     = out_p;
  assign bus_io.mul_a     = mul_a;
  assign bus_io.mul_b     = mul_b;
  assign bus_io.mul_en    = mul_en;
endmodule

// File: tb/tb_mul_2bit_gather.sv
// Directed and random checks of mul_2bit_gather against a registered 2-bit multiplier model.
module tb_mul_2bit_gather;
  logic clk;
  logic reset;

  int checks   = 0;
  int failures = 0;

  int          lat;
  int          en_cnt;
  int          rdy_hi;
  int          unstable;
  int          ov_seen;
  logic [31:0] seq_a;
  logic [31:0] seq_b;
  logic [15:0] got_p;
  logic [7:0]  ra, rb;
  logic [3:0]  qa, qb;

  mul_2bit_gather_if #(.WIDTH(8)) if0 ();
  mul_2bit_gather_if #(.WIDTH(8)) if1 ();
  mul_2bit_gather_if #(.WIDTH(4)) if2 ();

  mul_2bit_gather #(.WIDTH(8), .MUL_LAT(1)) dut0 (.clk(clk), .reset(reset), .bus_io(if0));
  mul_2bit_gather #(.WIDTH(8), .MUL_LAT(3)) dut1 (.clk(clk), .reset(reset), .bus_io(if1));
  mul_2bit_gather #(.WIDTH(4), .MUL_LAT(3)) dut2 (.clk(clk), .reset(reset), .bus_io(if2));

  // Multiplier models: garbage (0xF) whenever no digit pair was issued.
  logic [3:0] m0_q;
  logic [3:0] m1_q [3];
  logic [3:0] m2_q [3];

  always_ff @(posedge clk) begin
    m0_q    <= if0.mul_en ? ({2'b00, if0.mul_a} * {2'b00, if0.mul_b}) : 4'hF;
    m1_q[0] <= if1.mul_en ? ({2'b00, if1.mul_a} * {2'b00, if1.mul_b}) : 4'hF;
    m1_q[1] <= m1_q[0];
    m1_q[2] <= m1_q[1];
    m2_q[0] <= if2.mul_en ? ({2'b00, if2.mul_a} * {2'b00, if2.mul_b}) : 4'hF;
    m2_q[1] <= m2_q[0];
    m2_q[2] <= m2_q[1];
  end

  assign if0.mul_p = m0_q;
  assign if1.mul_p = m1_q[2];
  assign if2.mul_p = m2_q[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on dut0; out_ready is held low for `hold` cycles of out_valid.
  task automatic op0(input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [15:0] p0;
    @(negedge clk);
    chk("op_in_ready_idle", 32'(if0.in_ready), 32'd1);
    if0.in_valid = 1'b1;
    if0.in_a     = a;
    if0.in_b     = b;
    @(posedge clk);
    @(negedge clk);
    if0.in_valid = 1'b0;
    if0.in_a     = ~a;
    if0.in_b     = ~b;
    lat    = 0;
    en_cnt = 0;
    rdy_hi = 0;
    seq_a  = '0;
    seq_b  = '0;
    while (!if0.out_valid && lat < 200) begin
      if (if0.in_ready) rdy_hi++;
      if (if0.mul_en) begin
        en_cnt++;
        seq_a = {seq_a[29:0], if0.mul_a};
        seq_b = {seq_b[29:0], if0.mul_b};
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got_p    = if0.out_p;
    p0       = got_p;
    unstable = 0;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      if (if0.out_p !== p0 || if0.out_valid !== 1'b1) unstable++;
      if (if0.in_ready) rdy_hi++;
    end
    if0.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if0.out_ready = 1'b0;
    chk("post_hs_in_ready", 32'(if0.in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(if0.out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    if0.in_valid = 1'b0; if0.in_a = '0; if0.in_b = '0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.in_a = '0; if2.in_b = '0; if2.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(if0.in_ready), 32'd1);
    chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
    chk("rst_out_p", 32'(if0.out_p), 32'd0);
    chk("rst_mul_en", 32'(if0.mul_en), 32'd0);
    chk("rst_mul_a", 32'(if0.mul_a), 32'd0);
    chk("rst_mul_b", 32'(if0.mul_b), 32'd0);
    reset = 1'b0;

    // Zero operand: latency 16+1+1, in_ready low throughout.
    op0(8'h00, 8'hFF, 0);
    chk("zero_p", 32'(got_p), 32'h0000);
    chk("zero_lat", 32'(lat), 32'd18);
    chk("zero_rdy_low", 32'(rdy_hi), 32'd0);
    chk("zero_en_cnt", 32'(en_cnt), 32'd16);

    // Maximum product, top digit must not truncate.
    op0(8'hFF, 8'hFF, 0);
    chk("max_p", 32'(got_p), 32'hFE01);
    chk("max_lat", 32'(lat), 32'd18);

    // Digit order: A = 3,2,1,0 (MSB..LSB) and B = 0,1,2,3; 228*27 = 6156.
    op0(8'hE4, 8'h1B, 0);
    chk("order_seq_a", seq_a, 32'h0055AAFF);
    chk("order_seq_b", seq_b, 32'hE4E4E4E4);
    chk("order_en_cnt", 32'(en_cnt), 32'd16);
    chk("order_p", 32'(got_p), 32'h180C);

    // Backpressure: 165*60 = 9900 held for 5 cycles.
    op0(8'hA5, 8'h3C, 5);
    chk("hold_p", 32'(got_p), 32'h26AC);
    chk("hold_stable", 32'(unstable), 32'd0);
    chk("hold_rdy_low", 32'(rdy_hi), 32'd0);
    chk("hold_lat", 32'(lat), 32'd18);

    // Abort at the seventh issue cycle.
    @(negedge clk);
    if0.in_valid = 1'b1;
    if0.in_a     = 8'hFF;
    if0.in_b     = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    if0.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_mid_issue", 32'(if0.mul_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_in_ready", 32'(if0.in_ready), 32'd1);
    chk("abort_mul_en", 32'(if0.mul_en), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    ov_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (if0.out_valid) ov_seen++;
    end
    chk("abort_no_output", 32'(ov_seen), 32'd0);
    op0(8'h03, 8'h02, 0);
    chk("after_abort_p", 32'(got_p), 32'h0006);
    chk("after_abort_lat", 32'(lat), 32'd18);

    // Random back-to-back, WIDTH=8, MUL_LAT=3: latency 16+3+1.
    if1.out_ready = 1'b1;
    for (int n = 0; n < 500; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      @(negedge clk);
      chk("r8_in_ready", 32'(if1.in_ready), 32'd1);
      if1.in_valid = 1'b1;
      if1.in_a     = ra;
      if1.in_b     = rb;
      @(posedge clk);
      @(negedge clk);
      if1.in_valid = 1'b0;
      if1.in_a     = 8'($urandom);
      if1.in_b     = 8'($urandom);
      lat = 0;
      while (!if1.out_valid && lat < 100) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      chk("r8_p", 32'(if1.out_p), 32'({8'h00, ra} * {8'h00, rb}));
      chk("r8_lat", 32'(lat), 32'd20);
      @(posedge clk);
    end

    // Random back-to-back, WIDTH=4, MUL_LAT=3: latency 4+3+1.
    if2.out_ready = 1'b1;
    for (int n = 0; n < 500; n++) begin
      qa = 4'($urandom_range(15));
      qb = 4'($urandom_range(15));
      @(negedge clk);
      chk("r4_in_ready", 32'(if2.in_ready), 32'd1);
      if2.in_valid = 1'b1;
      if2.in_a     = qa;
      if2.in_b     = qb;
      @(posedge clk);
      @(negedge clk);
      if2.in_valid = 1'b0;
      if2.in_a     = 4'($urandom_range(15));
      if2.in_b     = 4'($urandom_range(15));
      lat = 0;
      while (!if2.out_valid && lat < 100) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      chk("r4_p", 32'(if2.out_p), 32'({4'h0, qa} * {4'h0, qb}));
      chk("r4_lat", 32'(lat), 32'd8);
      @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
